pool_out_buffer: RTL and testbench

//   Result buffer downstream of the pooling engine.
//   - Captures each pooled value from the engine (sum_out / out_dest_addr / dest_wr_en) into a DEPTH-entry buffer.
//   - When the engine signals done, drains the entries in address order over a valid/ready stream to the writeback stage.
//   - Decouples the engine's scattered write order from in-order consumption.

---
 rtl/npu_pool_pkg.sv | 17 +
 rtl/pool_out_mem.sv | 61 ++++++
 rtl/pool_out_buffer.sv | 180 ++++++++++++++++++
 tb/tb_pool_out_buffer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pool_pkg.sv
// rtl/npu_pool_pkg.sv - shared pooling constants and state encoding
// Purpose: defaults shared between the pooling engine and its output buffer,
//   plus the output-buffer state encoding.
// Ports: none (package).
package npu_pool_pkg;

  localparam int POOL_BIT_DEPTH = 8;
  localparam int POOL_DEPTH     = 32;
  localparam int POOL_ADDR_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } pool_state_e;

endpackage

// File: rtl/pool_out_mem.sv
// rtl/pool_out_mem.sv - result register array with valid bitmap
// Purpose: DEPTH x BIT_DEPTH storage with a per-entry valid bit. Reads are
//   masked by the valid bit so never-written entries read back as zero.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset (clears bitmap)
//   i_clr              clears the valid bitmap (frame start)
//   i_wr_en            write strobe (caller guarantees an accepted write)
//   i_wr_addr          write address
//   i_wr_data          write data
//   o_wr_hit           valid bit at i_wr_addr before this cycle's write
//   i_rd_addr          combinational read address
//   o_rd_data          masked read data
module pool_out_mem
  import npu_pool_pkg::*;
#(
  parameter int BIT_DEPTH = POOL_BIT_DEPTH,
  parameter int DEPTH     = POOL_DEPTH,
  parameter int ADDR_W    = POOL_ADDR_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_wr_en,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [BIT_DEPTH-1:0] i_wr_data,
  output logic                 o_wr_hit,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  output logic [BIT_DEPTH-1:0] o_rd_data
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [DEPTH-1:0]     r_valid;
  logic [BIT_DEPTH-1:0] r_mem [0:DEPTH-1];

  logic w_wr_in_range;
  logic w_rd_in_range;

  assign w_wr_in_range = {1'b0, i_wr_addr} < DEPTH_W;
  assign w_rd_in_range = {1'b0, i_rd_addr} < DEPTH_W;

  // Clear wins over a same-cycle write; the controller never issues both.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_valid <= '0;
    end else if (i_wr_en && w_wr_in_range) begin
      r_valid[i_wr_addr] <= 1'b1;
    end
  end

  // Data array has no reset: contents are masked by the bitmap.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && w_wr_in_range) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_wr_hit  = w_wr_in_range && r_valid[i_wr_addr];
  assign o_rd_data = (w_rd_in_range && r_valid[i_rd_addr]) ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/pool_out_buffer.sv
// rtl/pool_out_buffer.sv - pooled-result reorder buffer with in-order drain
// Purpose: collects scattered pooled writes from the engine, then drains all
//   addresses 0..hw_addr in order over a valid/ready stream.
// Optional feature: define POOL_OUT_RELU_EN to store negative values as 0.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 clear buffer and (re)enter COLLECT
//   i_wr_en/i_wr_addr/i_wr_data  engine result write
//   i_pool_done             engine done, ends collection
//   o_m_valid/o_m_data/o_m_addr/o_m_last, i_m_ready  drain stream
//   o_busy                  state != IDLE
//   o_drain_done            one-cycle pulse after frame completion
//   o_count                 distinct entries written this frame
//   o_wr_err                sticky write error
module pool_out_buffer
  import npu_pool_pkg::*;
#(
  parameter int BIT_DEPTH = POOL_BIT_DEPTH,
  parameter int DEPTH     = POOL_DEPTH,
  parameter int ADDR_W    = POOL_ADDR_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_wr_en,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [BIT_DEPTH-1:0] i_wr_data,
  input  logic                 i_pool_done,
  output logic                 o_m_valid,
  input  logic                 i_m_ready,
  output logic [BIT_DEPTH-1:0] o_m_data,
  output logic [ADDR_W-1:0]    o_m_addr,
  output logic                 o_m_last,
  output logic                 o_busy,
  output logic                 o_drain_done,
  output logic [ADDR_W:0]      o_count,
  output logic                 o_wr_err
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  pool_state_e          r_state;
  pool_state_e          w_state_nxt;
  logic [ADDR_W:0]      r_count;
  logic [ADDR_W-1:0]    r_hw_addr;
  logic [ADDR_W-1:0]    r_rd_ptr;
  logic                 r_wr_err;
  logic                 r_drain_done;

  logic                 w_in_range;
  logic                 w_wr_hit;
  logic                 w_mem_wr;
  logic                 w_new_entry;
  logic                 w_err_evt;
  logic                 w_is_last;
  logic                 w_xfer;
  logic                 w_done_collect;
  logic                 w_finish;
  logic [ADDR_W:0]      w_count_post;
  logic [BIT_DEPTH-1:0] w_wr_data;
  logic [BIT_DEPTH-1:0] w_rd_data;

`ifdef POOL_OUT_RELU_EN
  assign w_wr_data = i_wr_data[BIT_DEPTH-1] ? '0 : i_wr_data;
`else
  assign w_wr_data = i_wr_data;
`endif

  assign w_in_range  = {1'b0, i_wr_addr} < DEPTH_W;
  // start pre-empts any write in the same cycle.
  assign w_mem_wr    = (r_state == ST_COLLECT) && i_wr_en && !i_start && w_in_range;
  assign w_new_entry = w_mem_wr && !w_wr_hit;
  // Count including a write landing in the pool_done cycle.
  assign w_count_post = r_count + {{ADDR_W{1'b0}}, w_new_entry};
  assign w_err_evt   = i_wr_en && ((r_state != ST_COLLECT) || !w_in_range || w_wr_hit);

  assign w_is_last      = (r_rd_ptr == r_hw_addr);
  assign w_xfer         = (r_state == ST_DRAIN) && i_m_ready;
  assign w_done_collect = (r_state == ST_COLLECT) && i_pool_done;
  // Frame completes either on an empty pool_done or on the last drain beat.
  assign w_finish = !i_start &&
                    ((w_done_collect && (w_count_post == '0)) || (w_xfer && w_is_last));

  pool_out_mem #(
    .BIT_DEPTH (BIT_DEPTH),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_mem (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (i_start),
    .i_wr_en   (w_mem_wr),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (w_wr_data),
    .o_wr_hit  (w_wr_hit),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_start) begin
      w_state_nxt = ST_COLLECT;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (i_pool_done) begin
            w_state_nxt = (w_count_post == '0) ? ST_IDLE : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_xfer && w_is_last) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count      <= '0;
      r_hw_addr    <= '0;
      r_rd_ptr     <= '0;
      r_wr_err     <= 1'b0;
      r_drain_done <= 1'b0;
    end else begin
      r_drain_done <= w_finish;
      if (i_start) begin
        r_count   <= '0;
        r_hw_addr <= '0;
        r_rd_ptr  <= '0;
        r_wr_err  <= 1'b0;
      end else begin
        if (w_mem_wr) begin
          r_count <= w_count_post;
          if (i_wr_addr > r_hw_addr) begin
            r_hw_addr <= i_wr_addr;
          end
        end
        if (w_err_evt) begin
          r_wr_err <= 1'b1;
        end
        if (w_done_collect) begin
          r_rd_ptr <= '0;
        end else if (w_xfer && !w_is_last) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_m_valid = 1'b0;
    o_m_addr  = '0;
    o_m_data  = '0;
    o_m_last  = 1'b0;
    o_busy    = (r_state != ST_IDLE);
    if (r_state == ST_DRAIN) begin
      o_m_valid = 1'b1;
      o_m_addr  = r_rd_ptr;
      o_m_data  = w_rd_data;
      o_m_last  = w_is_last;
    end
  end

  assign o_drain_done = r_drain_done;
  assign o_count      = r_count;
  assign o_wr_err     = r_wr_err;

endmodule

// File: tb/tb_pool_out_buffer.sv
// tb/tb_pool_out_buffer.sv - self-checking bench for pool_out_buffer
module tb_pool_out_buffer;
  import npu_pool_pkg::*;

  localparam int BD = POOL_BIT_DEPTH;
  localparam int DP = POOL_DEPTH;
  localparam int AW = POOL_ADDR_W;

  logic          clk = 1'b0;
  logic          rst, start, wr_en, pool_done, m_ready;
  logic [AW-1:0] wr_addr;
  logic [BD-1:0] wr_data;
  logic          m_valid, m_last, busy, drain_done, wr_err;
  logic [BD-1:0] m_data;
  logic [AW-1:0] m_addr;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  pool_out_buffer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_pool_done  (pool_done),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready),
    .o_m_data     (m_data),
    .o_m_addr     (m_addr),
    .o_m_last     (m_last),
    .o_busy       (busy),
    .o_drain_done (drain_done),
    .o_count      (count),
    .o_wr_err     (wr_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a plain array of stored values plus a written flag.
  logic [BD-1:0] mdl_mem [DP];
  bit            mdl_vld [DP];
  int            mdl_cnt;
  int            mdl_hw;
  bit            mdl_err;

  logic [AW-1:0] wa [$];
  logic [BD-1:0] wd [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void mdl_clear();
    for (int i = 0; i < DP; i++) mdl_vld[i] = 1'b0;
    mdl_cnt = 0;
    mdl_hw  = 0;
    mdl_err = 1'b0;
  endfunction

  function automatic void mdl_write(input int a, input logic [BD-1:0] d);
    logic [BD-1:0] v;
    v = d;
`ifdef POOL_OUT_RELU_EN
    if ($signed(v) < 0) v = '0;
`endif
    if (a >= DP) begin
      mdl_err = 1'b1;
    end else begin
      if (mdl_vld[a]) mdl_err = 1'b1;
      else mdl_cnt++;
      mdl_vld[a] = 1'b1;
      mdl_mem[a] = v;
      if (a > mdl_hw) mdl_hw = a;
    end
  endfunction

  task automatic do_start(input string nm);
    start = 1'b1;
    tick;
    start = 1'b0;
    mdl_clear();
    chk({nm, "_start_busy"}, 32'(busy), 32'd1);
    chk({nm, "_start_count"}, 32'(count), 32'd0);
    chk({nm, "_start_err"}, 32'(wr_err), 32'd0);
    chk({nm, "_start_valid"}, 32'(m_valid), 32'd0);
    chk({nm, "_start_nodone"}, 32'(drain_done), 32'd0);
  endtask

  // ready_mode: 0 always ready, 1 toggle starting at 1, 2 random.
  // abort_at >= 0 stops after that many beats, leaving the frame in DRAIN.
  task automatic run_frame(input string nm, input bit done_with_last, input int ready_mode,
                           input bit drain_wr, input int abort_at);
    int  n;
    int  b;
    int  cyc;
    bit  rdy;
    bit  tog;
    logic [BD-1:0] exp_d;
    n = wa.size();
    for (int k = 0; k < n; k++) begin
      wr_en   = 1'b1;
      wr_addr = wa[k];
      wr_data = wd[k];
      if (done_with_last && k == n - 1) pool_done = 1'b1;
      mdl_write(int'(wa[k]), wd[k]);
      tick;
    end
    wr_en = 1'b0;
    if (!(done_with_last && n > 0)) begin
      pool_done = 1'b1;
      tick;
    end
    pool_done = 1'b0;
    if (mdl_cnt == 0) begin
      chk({nm, "_empty_valid"}, 32'(m_valid), 32'd0);
      chk({nm, "_empty_done"}, 32'(drain_done), 32'd1);
      chk({nm, "_empty_busy"}, 32'(busy), 32'd0);
      tick;
      chk({nm, "_empty_done_pulse"}, 32'(drain_done), 32'd0);
    end else begin
      b   = 0;
      cyc = 0;
      tog = 1'b1;
      while (b <= mdl_hw && cyc < 500 && !(abort_at >= 0 && b == abort_at)) begin
        exp_d = mdl_vld[b] ? mdl_mem[b] : '0;
        chk({nm, "_valid"}, 32'(m_valid), 32'd1);
        chk({nm, "_addr"}, 32'(m_addr), 32'(b));
        chk({nm, "_data"}, 32'(m_data), 32'(exp_d));
        chk({nm, "_last"}, 32'(m_last), 32'(b == mdl_hw));
        chk({nm, "_early_done"}, 32'(drain_done), 32'd0);
        case (ready_mode)
          0:       rdy = 1'b1;
          1:       begin rdy = tog; tog = !tog; end
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        m_ready = rdy;
        if (drain_wr && cyc == 0) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          mdl_err = 1'b1;
        end
        tick;
        wr_en = 1'b0;
        cyc++;
        if (rdy) b++;
      end
      m_ready = 1'b0;
      if (cyc >= 500) chk({nm, "_drain_timeout"}, 32'd0, 32'd1);
      if (abort_at < 0) begin
        chk({nm, "_done"}, 32'(drain_done), 32'd1);
        chk({nm, "_end_busy"}, 32'(busy), 32'd0);
        chk({nm, "_end_valid"}, 32'(m_valid), 32'd0);
        chk({nm, "_count"}, 32'(count), 32'(mdl_cnt));
        chk({nm, "_err"}, 32'(wr_err), 32'(mdl_err));
        tick;
        chk({nm, "_done_pulse"}, 32'(drain_done), 32'd0);
      end
    end
    wa.delete();
    wd.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; pool_done = 1'b0; m_ready = 1'b0;
    wr_addr = '0; wr_data = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(wr_err), 32'd0);
    chk("rst_done", 32'(drain_done), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);

    // In-order four-entry frame.
    do_start("t1");
    wa = '{5'd0, 5'd1, 5'd2, 5'd3};
    wd = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame("t1", 1'b0, 0, 1'b0, -1);

    // Hole at addr1, stalls on ready.
    do_start("t2");
    wa = '{5'd2, 5'd0};
    wd = '{8'h7F, 8'h05};
    run_frame("t2", 1'b0, 1, 1'b0, -1);

    // Rewrite of a valid entry.
    do_start("t3");
    wa = '{5'd1, 5'd1};
    wd = '{8'h10, 8'h20};
    run_frame("t3", 1'b0, 0, 1'b0, -1);

    // Empty frame (start clears the sticky error from t3).
    do_start("t4");
    run_frame("t4", 1'b0, 0, 1'b0, -1);

    // Write coincident with pool_done, then abort mid-drain.
    do_start("t5");
    wa = '{5'd0, 5'd3};
    wd = '{8'h01, 8'h09};
    run_frame("t5", 1'b1, 0, 1'b0, 1);
    chk("t5_mid_busy", 32'(busy), 32'd1);
    do_start("t5b");
    wa = '{5'd1};
    wd = '{8'h3C};
    run_frame("t5b", 1'b0, 2, 1'b0, -1);

    // Negative value storage depends on the ReLU build option.
    do_start("t6");
    wa = '{5'd0, 5'd1};
    wd = '{8'h80, 8'h7F};
    run_frame("t6", 1'b0, 0, 1'b0, -1);

    // Writes and pool_done while idle.
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 8'hAB;
    tick;
    wr_en = 1'b0;
    chk("idle_wr_err", 32'(wr_err), 32'd1);
    chk("idle_wr_busy", 32'(busy), 32'd0);
    pool_done = 1'b1;
    tick;
    pool_done = 1'b0;
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_valid", 32'(m_valid), 32'd0);
    tick;
    chk("idle_done_nopulse", 32'(drain_done), 32'd0);

    // Randomised frames, including rewrites, drain-time writes and stalls.
    for (int f = 0; f < 12; f++) begin
      int n;
      do_start("rnd");
      n = $urandom_range(0, 10);
      for (int k = 0; k < n; k++) begin
        wa.push_back(AW'($urandom_range(0, DP - 1)));
        wd.push_back(BD'($urandom));
      end
      run_frame("rnd", 1'($urandom_range(0, 1)), 2, ($urandom_range(0, 3) == 0), -1);
    end

    // Reset during drain loses the frame without a done pulse.
    do_start("rst_mid");
    wa = '{5'd6};
    wd = '{8'h66};
    run_frame("rst_mid", 1'b0, 0, 1'b0, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_mid_valid", 32'(m_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_done", 32'(drain_done), 32'd0);
    tick;
    chk("rst_mid_done2", 32'(drain_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
